// File: rtl/cle_label_stats.sv
// Post-CLE statistics: scans the labeled 32x32 image in raster order, accumulates per-label
// area and bounding box, then streams one record per allocated label over valid/ready.
module cle_label_stats #(
  parameter int MAX_LABELS = 8,
  parameter int AREA_W     = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [9:0]        sram_a,
  input  logic [7:0]        sram_q,
  output logic              busy,
  output logic              obj_valid,
  input  logic              obj_ready,
  output logic [7:0]        obj_label,
  output logic [AREA_W-1:0] obj_area,
  output logic [4:0]        obj_rmin,
  output logic [4:0]        obj_rmax,
  output logic [4:0]        obj_cmin,
  output logic [4:0]        obj_cmax,
  output logic [3:0]        obj_count,
  output logic              overflow,
  output logic              done
);

  localparam int IDX_W = (MAX_LABELS > 1) ? $clog2(MAX_LABELS) : 1;
  localparam int CNT_W = $clog2(MAX_LABELS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [IDX_W-1:0] emit_idx;
  logic [CNT_W-1:0] ent_cnt;
  logic             ovf;

  logic [7:0]        tbl_lbl  [MAX_LABELS];
  logic [AREA_W-1:0] tbl_area [MAX_LABELS];
  logic [4:0]        tbl_rmin [MAX_LABELS];
  logic [4:0]        tbl_rmax [MAX_LABELS];
  logic [4:0]        tbl_cmin [MAX_LABELS];
  logic [4:0]        tbl_cmax [MAX_LABELS];

  logic       vld_p0;
  logic [4:0] row_p0;
  logic [4:0] col_p0;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             pix_live;
  logic             do_upd;
  logic             do_alloc;
  logic             do_drop;
  logic [CNT_W-1:0] cnt_nxt;

  function automatic logic [AREA_W-1:0] sat_inc(input logic [AREA_W-1:0] a);
    return (a == {AREA_W{1'b1}}) ? a : a + AREA_W'(1);
  endfunction

  function automatic logic [4:0] min5(input logic [4:0] a, input logic [4:0] b);
    return (b < a) ? b : a;
  endfunction

  function automatic logic [4:0] max5(input logic [4:0] a, input logic [4:0] b);
    return (b > a) ? b : a;
  endfunction

  // Stage p1: sram_q now holds the pixel addressed last cycle; look it up in the table
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < MAX_LABELS; i++) begin
      if (!hit && (CNT_W'(i) < ent_cnt) && (tbl_lbl[i] == sram_q)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    pix_live = vld_p0 && (sram_q != 8'd0);
    do_upd   = pix_live && hit;
    do_alloc = pix_live && !hit && (ent_cnt < CNT_W'(MAX_LABELS));
    do_drop  = pix_live && !hit && (ent_cnt >= CNT_W'(MAX_LABELS));
    cnt_nxt  = ent_cnt + CNT_W'(do_alloc);
  end

  // Table contents are pure data; validity is defined by ent_cnt alone
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_LABELS; i++) begin
      if (do_upd && (hit_idx == IDX_W'(i))) begin
        tbl_area[i] <= sat_inc(tbl_area[i]);
        tbl_rmin[i] <= min5(tbl_rmin[i], row_p0);
        tbl_rmax[i] <= max5(tbl_rmax[i], row_p0);
        tbl_cmin[i] <= min5(tbl_cmin[i], col_p0);
        tbl_cmax[i] <= max5(tbl_cmax[i], col_p0);
      end else if (do_alloc && (ent_cnt == CNT_W'(i))) begin
        tbl_lbl[i]  <= sram_q;
        tbl_area[i] <= AREA_W'(1);
        tbl_rmin[i] <= row_p0;
        tbl_rmax[i] <= row_p0;
        tbl_cmin[i] <= col_p0;
        tbl_cmax[i] <= col_p0;
      end
    end
  end

  // Stage p0: remember which pixel the in-flight SRAM read belongs to
  always_ff @(posedge clk) begin
    row_p0 <= sram_a[9:5];
    col_p0 <= sram_a[4:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      sram_a   <= '0;
      vld_p0   <= 1'b0;
      ent_cnt  <= '0;
      ovf      <= 1'b0;
      emit_idx <= '0;
    end else begin
      vld_p0 <= (state == S_SCAN);
      if (do_alloc) ent_cnt <= cnt_nxt;
      if (do_drop)  ovf     <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            ent_cnt <= '0;
            ovf     <= 1'b0;
            sram_a  <= '0;
            state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (sram_a == 10'd1023) begin
            sram_a <= '0;
            state  <= S_DRAIN;
          end else begin
            sram_a <= sram_a + 10'd1;
          end
        end
        S_DRAIN: begin
          emit_idx <= '0;
          state    <= (cnt_nxt == '0) ? S_DONE : S_EMIT;
        end
        S_EMIT: begin
          if (obj_ready) begin
            if ((CNT_W'(emit_idx) + CNT_W'(1)) == ent_cnt) begin
              state <= S_DONE;
            end else begin
              emit_idx <= emit_idx + IDX_W'(1);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p2: record presentation straight from the table, zeroed outside EMIT
  always_comb begin
    obj_valid = (state == S_EMIT);
    busy      = (state == S_SCAN) || (state == S_DRAIN) || (state == S_EMIT);
    done      = (state == S_DONE);
    obj_count = 4'(ent_cnt);
    overflow  = ovf;
    obj_label = '0;
    obj_area  = '0;
    obj_rmin  = '0;
    obj_rmax  = '0;
    obj_cmin  = '0;
    obj_cmax  = '0;
    if (obj_valid) begin
      obj_label = tbl_lbl[emit_idx];
      obj_area  = tbl_area[emit_idx];
      obj_rmin  = tbl_rmin[emit_idx];
      obj_rmax  = tbl_rmax[emit_idx];
      obj_cmin  = tbl_cmin[emit_idx];
      obj_cmax  = tbl_cmax[emit_idx];
    end
  end

endmodule

// File: tb/tb_cle_label_stats.sv
// Directed bench for cle_label_stats: scenario table of images with expected record lists,
// plus a hand-written mid-scan reset sequence.
module tb_cle_label_stats;
  localparam int AREA_W = 11;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              obj_ready = 1'b1;
  logic [9:0]        sram_a;
  logic [7:0]        sram_q;
  logic              busy, obj_valid, overflow, done;
  logic [7:0]        obj_label;
  logic [AREA_W-1:0] obj_area;
  logic [4:0]        obj_rmin, obj_rmax, obj_cmin, obj_cmax;
  logic [3:0]        obj_count;

  logic [7:0] mem [1024];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] label;
    int area;
    int rmin;
    int rmax;
    int cmin;
    int cmax;
  } rec_t;

  typedef struct {
    int img;
    int first;
    int n;
    bit ovf;
    int stall;
    bit mid_start;
  } scen_t;

  rec_t  exp_tab [12];
  scen_t scen [5];

  cle_label_stats #(.MAX_LABELS(8), .AREA_W(AREA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .sram_a(sram_a), .sram_q(sram_q),
    .busy(busy), .obj_valid(obj_valid), .obj_ready(obj_ready), .obj_label(obj_label),
    .obj_area(obj_area), .obj_rmin(obj_rmin), .obj_rmax(obj_rmax), .obj_cmin(obj_cmin),
    .obj_cmax(obj_cmax), .obj_count(obj_count), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sram_q <= mem[sram_a];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input int i);
    chk({tag, "_label"}, 32'(obj_label), 32'(exp_tab[i].label));
    chk({tag, "_area"},  32'(obj_area),  exp_tab[i].area);
    chk({tag, "_rmin"},  32'(obj_rmin),  exp_tab[i].rmin);
    chk({tag, "_rmax"},  32'(obj_rmax),  exp_tab[i].rmax);
    chk({tag, "_cmin"},  32'(obj_cmin),  exp_tab[i].cmin);
    chk({tag, "_cmax"},  32'(obj_cmax),  exp_tab[i].cmax);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sram_a"},   32'(sram_a), 0);
    chk({tag, "_busy"},     32'(busy), 0);
    chk({tag, "_valid"},    32'(obj_valid), 0);
    chk({tag, "_label"},    32'(obj_label), 0);
    chk({tag, "_area"},     32'(obj_area), 0);
    chk({tag, "_bbox"},     32'({obj_rmin, obj_rmax, obj_cmin, obj_cmax}), 0);
    chk({tag, "_count"},    32'(obj_count), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_done"},     32'(done), 0);
  endtask

  task automatic load_img(input int id);
    for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
    case (id)
      1: mem[33] = 8'h05;
      2: begin
        for (int r = 2; r <= 4; r++)
          for (int c = 6; c <= 9; c++) mem[r*32+c] = 8'h10;
        for (int c = 0; c < 32; c++) mem[30*32+c] = 8'h02;
      end
      3: for (int i = 0; i < 9; i++) mem[i] = 8'(i + 1);
      default: ;
    endcase
  endtask

  task automatic run_scen(input scen_t s);
    int cyc, got, stall_cnt, last_acc;
    bit first_v, fin, acc_prev;
    load_img(s.img);
    obj_ready = (s.stall == 0);
    @(negedge clk);
    start = 1'b1;
    cyc = 0; got = 0; stall_cnt = 0; last_acc = -1;
    first_v = 0; fin = 0; acc_prev = 0;
    while (!fin && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) begin
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
      end
      if (s.mid_start && cyc == 300) start = 1'b1;
      if (cyc == 301) start = 1'b0;
      if (acc_prev && got < s.n) chk("no_bubble", 32'(obj_valid), 1);
      acc_prev = 0;
      if (obj_valid) begin
        if (!first_v) begin
          first_v = 1;
          chk("valid_latency", cyc, 1026);
        end
        if (got == 0 && stall_cnt < s.stall) begin
          chk_rec("held", s.first);
          stall_cnt++;
          if (stall_cnt == s.stall) obj_ready = 1'b1;
        end
        if (obj_ready) begin
          if (got < s.n) chk_rec("rec", s.first + got);
          else chk("extra_record", 1, 0);
          got++;
          last_acc = cyc;
          acc_prev = 1;
        end
      end
      if (done) begin
        fin = 1;
        if (s.n == 0) chk("done_latency", cyc, 1026);
        else chk("done_after_last", cyc, last_acc + 1);
        chk("record_count", got, s.n);
        chk("obj_count", 32'(obj_count), s.n);
        chk("overflow", 32'(overflow), 32'(s.ovf));
        chk("busy_at_done", 32'(busy), 0);
        chk("valid_at_done", 32'(obj_valid), 0);
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
    obj_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 0);
    chk("count_held", 32'(obj_count), s.n);
  endtask

  initial begin
    exp_tab[0] = '{8'h05, 1, 1, 1, 1, 1};
    exp_tab[1] = '{8'h10, 12, 2, 4, 6, 9};
    exp_tab[2] = '{8'h02, 32, 30, 30, 0, 31};
    for (int i = 0; i < 8; i++) exp_tab[3+i] = '{8'(i + 1), 1, 0, 0, i, i};
    exp_tab[11] = '{8'h00, 0, 0, 0, 0, 0};

    scen[0] = '{0, 0, 0, 1'b0, 0,  1'b0};
    scen[1] = '{1, 0, 1, 1'b0, 0,  1'b0};
    scen[2] = '{2, 1, 2, 1'b0, 0,  1'b1};
    scen[3] = '{3, 3, 8, 1'b1, 0,  1'b0};
    scen[4] = '{2, 1, 2, 1'b0, 20, 1'b0};

    load_img(0);
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 5; k++) run_scen(scen[k]);

    // Reset mid-scan, then rerun image 2
    begin
      int w;
      load_img(2);
      @(negedge clk);
      start = 1'b1;
      w = 0;
      while (w < 2000) begin
        @(posedge clk);
        #1;
        start = 1'b0;
        w++;
        if (sram_a == 10'd500) break;
      end
      chk("reach_addr_500", 32'(sram_a), 500);
      reset = 1'b1;
      #1;
      chk_all_zero("midreset");
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("midreset_hold");
      @(negedge clk);
      reset = 1'b0;
      run_scen(scen[2]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
